updown_mod_counter: RTL and testbench

Parametrised successor to the team's fixed 3-bit up counter. Provides a WIDTH-bit up/down counter with a runtime-programmable modulus, synchronous parallel load, count enable, and a selectable wrap or saturate mode. It also produces a terminal-count flag, a registered wrap pulse and a sticky overflow flag. Used as the general-purpose timer/sequencer element in control datapaths.

---
 rtl/updown_mod_counter_if.sv | 27 ++
 rtl/updown_mod_counter.sv | 64 ++++++
 tb/tb_updown_mod_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: master drives the controls,
// slave (the counter) returns count and flags.
interface updown_mod_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             dir;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap_p;
   logic             ovf;

   modport master (
      output en, dir, sat_mode, load, load_val, max_val, clr_ovf,
      input  count, tc, wrap_p, ovf
   );

   modport slave (
      input  en, dir, sat_mode, load, load_val, max_val, clr_ovf,
      output count, tc, wrap_p, ovf
   );
endinterface

// File: rtl/updown_mod_counter.sv
// WIDTH-bit up/down counter with runtime modulus, parallel load, wrap or
// saturate at the limits, terminal-count flag, wrap pulse and sticky overflow.
module updown_mod_counter #(
   parameter int WIDTH     = 8,
   parameter int RESET_VAL = 0
) (
   input logic                clk,
   input logic                rst,
   updown_mod_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] count_q, count_nxt;
   logic             wrap_q, ovf_q;
   logic             at_top, at_zero, above_max, limit_ev, step_ev;

   assign at_top    = (count_q >= bus.max_val);
   assign at_zero   = (count_q == '0);
   assign above_max = (count_q > bus.max_val);
   assign limit_ev  = bus.en & ((bus.dir & at_top) | (~bus.dir & at_zero));

   always_comb begin
      count_nxt = count_q;
      step_ev   = 1'b0;
      if (bus.load) begin
         count_nxt = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      end else if (bus.en) begin
         if (bus.dir) begin
            if (at_top) begin
               step_ev   = 1'b1;
               count_nxt = bus.sat_mode ? bus.max_val : '0;
            end else begin
               count_nxt = count_q + 1'b1;
            end
         end else if (at_zero) begin
            step_ev   = 1'b1;
            count_nxt = bus.sat_mode ? '0 : bus.max_val;
         end else if (above_max) begin
            // modulus lowered under a running count: snap down without an event
            count_nxt = bus.max_val;
         end else begin
            count_nxt = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RST_V;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wrap_q  <= step_ev;
         // set beats clear when both happen on the same edge
         ovf_q   <= step_ev | (ovf_q & ~bus.clr_ovf);
      end
   end

   assign bus.count  = count_q;
   assign bus.tc     = limit_ev;
   assign bus.wrap_p = wrap_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed-vector bench: the driver pushes the outputs expected during each
// vector's cycle into a queue; a negedge monitor pops and compares.
module tb_updown_mod_counter;
   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         tc;
      logic         wp;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(W)) if0 ();
   updown_mod_counter_if #(.WIDTH(W)) if1 ();

   updown_mod_counter #(.WIDTH(W), .RESET_VAL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   updown_mod_counter #(.WIDTH(W), .RESET_VAL(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   passed = 0;
   int   vec0 = 0;
   int   vec1 = 0;
   bit   done = 1'b0;

   // inputs are applied 1 time unit after a rising edge; the expectation
   // describes what the DUT shows during that same cycle
   task automatic step0(input logic r, en, dir, sat, ld, input logic [W-1:0] lv, mx,
                        input logic clr, input logic [W-1:0] ec, input logic etc, ewp, eovf);
      rst = r;
      if0.en = en; if0.dir = dir; if0.sat_mode = sat; if0.load = ld;
      if0.load_val = lv; if0.max_val = mx; if0.clr_ovf = clr;
      q0.push_back('{cnt: ec, tc: etc, wp: ewp, ovf: eovf});
      @(posedge clk); #1;
   endtask

   task automatic step1(input logic r, en, dir, sat, ld, input logic [W-1:0] lv, mx,
                        input logic clr, input logic [W-1:0] ec, input logic etc, ewp, eovf);
      rst = r;
      if1.en = en; if1.dir = dir; if1.sat_mode = sat; if1.load = ld;
      if1.load_val = lv; if1.max_val = mx; if1.clr_ovf = clr;
      q1.push_back('{cnt: ec, tc: etc, wp: ewp, ovf: eovf});
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      exp_t e, g;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         g = '{cnt: if0.count, tc: if0.tc, wp: if0.wrap_p, ovf: if0.ovf};
         checks++;
         if (g === e) passed++;
         else $display("FAIL dut0 vec %0d: got cnt=%0d tc=%b wp=%b ovf=%b, want cnt=%0d tc=%b wp=%b ovf=%b",
                       vec0, g.cnt, g.tc, g.wp, g.ovf, e.cnt, e.tc, e.wp, e.ovf);
         vec0++;
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         g = '{cnt: if1.count, tc: if1.tc, wp: if1.wrap_p, ovf: if1.ovf};
         checks++;
         if (g === e) passed++;
         else $display("FAIL dut1 vec %0d: got cnt=%0d tc=%b wp=%b ovf=%b, want cnt=%0d tc=%b wp=%b ovf=%b",
                       vec1, g.cnt, g.tc, g.wp, g.ovf, e.cnt, e.tc, e.wp, e.ovf);
         vec1++;
      end
   end

   initial begin
      rst = 1'b1;
      if0.en = 0; if0.dir = 0; if0.sat_mode = 0; if0.load = 0;
      if0.load_val = '0; if0.max_val = '0; if0.clr_ovf = 0;
      if1.en = 0; if1.dir = 0; if1.sat_mode = 0; if1.load = 0;
      if1.load_val = '0; if1.max_val = '0; if1.clr_ovf = 0;
      @(posedge clk); #1;

      // up/wrap over full range, max 15: 0..15,0,1,2,3
      for (int k = 0; k < 20; k++) begin
         logic [W-1:0] c;
         c = W'(k % 16);
         step0(0, 1, 1, 0, 0, 4'd0, 4'd15, 0, c, (k == 15), (k == 16), (k >= 16));
      end
      // down/wrap, max 9, load 2: 2,1,0,9,8 then clear ovf
      step0(0, 0, 0, 0, 1, 4'd2, 4'd9, 0, 4'd4, 0, 0, 1);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 4'd2, 0, 0, 1);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0, 1);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 4'd0, 1, 0, 1);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 4'd9, 0, 1, 1);
      step0(0, 0, 0, 0, 0, 4'd0, 4'd9, 1, 4'd8, 0, 0, 1);
      // saturate up, max 5, from 3: 3,4,5,5,5 then down 4,3
      step0(0, 0, 0, 0, 1, 4'd3, 4'd5, 0, 4'd8, 0, 0, 0);
      step0(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, 4'd3, 0, 0, 0);
      step0(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, 4'd4, 0, 0, 0);
      step0(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, 4'd5, 1, 0, 0);
      step0(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, 4'd5, 1, 1, 1);
      step0(0, 1, 0, 1, 0, 4'd0, 4'd5, 0, 4'd5, 0, 1, 1);
      step0(0, 1, 0, 1, 0, 4'd0, 4'd5, 0, 4'd4, 0, 0, 1);
      // load clamps to max, load beats en, lowered max snaps down silently
      step0(0, 0, 0, 0, 1, 4'd12, 4'd7, 0, 4'd3, 0, 0, 1);
      step0(0, 1, 1, 0, 1, 4'd2, 4'd7, 0, 4'd7, 1, 0, 1);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 4'd2, 0, 0, 1);
      step0(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 4'd1, 0, 0, 1);
      // ovf: set by wrap, clear coinciding with an event loses, clear alone wins
      step0(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 4'd1, 1, 0, 0);
      step0(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 4'd0, 0, 1, 1);
      step0(0, 1, 1, 0, 0, 4'd0, 4'd1, 1, 4'd1, 1, 0, 1);
      step0(0, 0, 1, 0, 0, 4'd0, 4'd1, 1, 4'd0, 0, 1, 1);
      // max_val = 0: every step is a limit event and count stays 0
      step0(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 0, 0);
      step0(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 1, 1);
      // reset together with load mid-count
      step0(0, 0, 0, 0, 1, 4'd6, 4'd9, 0, 4'd0, 0, 1, 1);
      step0(1, 1, 1, 0, 1, 4'd2, 4'd9, 0, 4'd6, 0, 0, 1);
      step0(0, 0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0, 0);

      // RESET_VAL = 3 instance (reset at time zero, idle since)
      step1(0, 0, 0, 0, 1, 4'd6, 4'd9, 0, 4'd3, 0, 0, 0);
      step1(0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 4'd6, 0, 0, 0);
      step1(1, 1, 1, 0, 1, 4'd2, 4'd9, 0, 4'd7, 0, 0, 0);
      step1(0, 0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd3, 0, 0, 0);

      @(posedge clk); #1;
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         #20000;
      join_any
      if (!done) begin
         checks++;
         $display("FAIL timeout: bench did not complete, want completion");
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
